viterbi_tbu_param: RTL and testbench
====================================

// Module: viterbi_tbu_param
// PURPOSE
//  Parametrised Viterbi traceback unit for 2^(K-1)-state trellises. Walks the
//  survivor-decision memory one state per cycle, selecting one of two
//  ping-pong decision banks. Emits one decoded bit per step to the LIFO/output
//  stage, plus a write enable and an end-of-window marker.
//  Sits between the ACS survivor memory and the bit-reversal buffer.
// PARAMETERS
//  K       4    constraint length; legal range 3..9; NS = 2**(K-1) states (localparam)
//  TB_LEN  16   traceback window length in steps; >=2; CW = $clog2(TB_LEN) (localparam)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, asynchronous, active-low
//  enable       in   1     0 = hold unit in restart
//  selection    in   1     1 = trace bank d_in_1 and emit; 0 = bank d_in_0, no emit
//  d_in_0       in   NS    decision bits of bank 0, indexed by current state
//  d_in_1       in   NS    decision bits of bank 1, indexed by current state
//  start_state  in   K-1   restart state (present only with TBU_START_STATE_EN)
//  d_o          out  1     decoded bit, registered
//  wr_en        out  1     d_o valid strobe, registered
//  d_last       out  1     pulses with wr_en on final step of a TB_LEN window
//  state_o      out  K-1   current traceback state (pstate)
// BEHAVIOUR
//  - Async reset: pstate=0, sel_buf=0, cnt=0, d_o=0, wr_en=0, d_last=0.
//  - sel_buf <= selection every clk. fall = sel_buf & ~selection.
//  - dbit = selection ? d_in_1[pstate] : d_in_0[pstate].
//  - nstate = {dbit, pstate[K-2:1]} (decision bit shifted into state MSB).
//  - pstate update, priority order:
//      !enable -> RST_ST; fall -> RST_ST; else -> nstate.
//    RST_ST = 0 (or start_state, see CONFIGURATION).
//  - Step counter cnt (CW bits):
//      !enable or fall -> 0.
//      enable & selection -> cnt+1; wraps TB_LEN-1 -> 0.
//      otherwise hold.
//  - Output register, latency 1 clk from the state visit:
//      wr_en  <= enable & selection.
//      d_o    <= (enable & selection) ? dbit : d_o (hold when not emitting).
//      d_last <= enable & selection & (cnt == TB_LEN-1).
//  - state_o = pstate (combinational from the register).
//  - Bank switch with no falling edge (0->1): no restart; trace continues from nstate.
//  - fall and enable=1 in the same cycle: restart wins; the selection=0 cycle emits nothing.
//  - Reset mid-window: all state cleared; the next window starts at cnt=0.
//  - Decision inputs must be stable in the cycle they are sampled; no input registering.
// CONFIGURATION
//  TBU_START_STATE_EN defined:
//    - start_state port exists.
//    - RST_ST = start_state, sampled in the restart cycle (best-metric start from ACS).
//  Undefined:
//    - Port absent; RST_ST = 0.
//    - Async reset value of pstate is 0 in both builds.
// TESTING (K=4, TB_LEN=16 unless noted)
//  1. rst low, then high; enable=1, selection=1, d_in_1=8'hFF
//     -> state_o 0,4,6,7,7...; d_o=1, wr_en=1 from 2nd clk on.
//  2. enable=1, selection=1, d_in_1=8'h00 -> state_o stays 0; d_o=0, wr_en=1.
//  3. Run test 1 for 3 clks, then selection 1->0
//     -> state_o=0 next clk; wr_en=0; d_o holds 1; cnt=0.
//  4. selection=1 held 20 clks -> d_last=1 only on wr_en pulses 16; no other wr_en cycle.
//  5. Mid-trace enable=0 for 1 clk -> state_o=0, cnt=0, wr_en=0 next clk.
//     Async rst pulse mid-trace -> all outputs 0 immediately.
//  6. TBU_START_STATE_EN, start_state=5, d_in_1=8'h00, fall then selection=1
//     -> state_o 5,2,1,0.

Source files
------------

// File: rtl/viterbi_tbu_param.sv
// Viterbi traceback unit: walks the survivor-decision memory one state per cycle and emits one decoded bit per step.
// Optional build macro TBU_START_STATE_EN adds a start_state port used as the restart state.
module viterbi_tbu_param #(
    parameter int unsigned K      = 4,
    parameter int unsigned TB_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  selection,
    input  logic [2**(K-1)-1:0]   d_in_0,
    input  logic [2**(K-1)-1:0]   d_in_1,
`ifdef TBU_START_STATE_EN
    input  logic [K-2:0]          start_state,
`endif
    output logic                  d_o,
    output logic                  wr_en,
    output logic                  d_last,
    output logic [K-2:0]          state_o
);

    localparam int unsigned SW = K - 1;
    localparam int unsigned CW = $clog2(TB_LEN);

    logic [SW-1:0] pstate;
    logic [SW-1:0] nstate;
    logic [SW-1:0] rst_st;
    logic [CW-1:0] cnt;
    logic          sel_buf;
    logic          dbit;
    logic          fall;
    logic          emit;
    logic          restart;
    logic          cnt_last;

`ifdef TBU_START_STATE_EN
    assign rst_st = start_state;
`else
    assign rst_st = '0;
`endif

    // Decision lookup and next-state formation: the decision bit enters at the state MSB.
    always_comb begin
        dbit     = selection ? d_in_1[pstate] : d_in_0[pstate];
        nstate   = {dbit, pstate[SW-1:1]};
        fall     = sel_buf & ~selection;
        emit     = enable & selection;
        restart  = ~enable | fall;
        cnt_last = (cnt == CW'(TB_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstate  <= '0;
            sel_buf <= 1'b0;
            cnt     <= '0;
            d_o     <= 1'b0;
            wr_en   <= 1'b0;
            d_last  <= 1'b0;
        end else begin
            sel_buf <= selection;
            pstate  <= restart ? rst_st : nstate;

            if (restart)
                cnt <= '0;
            else if (emit)
                cnt <= cnt_last ? '0 : cnt + CW'(1);

            // Output stage lags the state visit by one clock; d_o holds between emits.
            wr_en  <= emit;
            d_last <= emit & cnt_last;
            if (emit)
                d_o <= dbit;
        end
    end

    assign state_o = pstate;

endmodule

// File: tb/tb_viterbi_tbu_param.sv
// Self-checking bench for viterbi_tbu_param (K=4, TB_LEN=16): directed vector table, corner sequences, random vs model.
module tb_viterbi_tbu_param;

    localparam int unsigned K      = 4;
    localparam int unsigned TB_LEN = 16;
    localparam int unsigned NS     = 8;
    localparam int unsigned SW     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          selection = 1'b0;
    logic [NS-1:0] d_in_0 = '0;
    logic [NS-1:0] d_in_1 = '0;
`ifdef TBU_START_STATE_EN
    logic [SW-1:0] start_state = '0;
`endif
    logic          d_o;
    logic          wr_en;
    logic          d_last;
    logic [SW-1:0] state_o;

    int checks = 0;
    int errors = 0;

    // Reference model: traceback state as an integer, window position as a step index.
    int m_state, m_cnt, m_start;
    bit m_prev_sel, m_do, m_wr, m_last;

    viterbi_tbu_param #(.K(K), .TB_LEN(TB_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .selection  (selection),
        .d_in_0     (d_in_0),
        .d_in_1     (d_in_1),
`ifdef TBU_START_STATE_EN
        .start_state(start_state),
`endif
        .d_o        (d_o),
        .wr_en      (wr_en),
        .d_last     (d_last),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          sel;
        logic [NS-1:0] d0;
        logic [NS-1:0] d1;
        logic [SW-1:0] st;
        logic          dout;
        logic          wr;
        logic          last;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_prev_sel = 0;
        m_do = 0; m_wr = 0; m_last = 0;
    endtask

    // One clock of the traceback rules applied to the currently driven inputs.
    task automatic model_step();
        bit emit, restart, dbit;
        int rs;
`ifdef TBU_START_STATE_EN
        rs = int'(start_state);
`else
        rs = 0;
`endif
        emit    = enable && selection;
        restart = !enable || (m_prev_sel && !selection);
        dbit    = selection ? d_in_1[m_state] : d_in_0[m_state];
        m_wr    = emit;
        m_last  = emit && (m_cnt == TB_LEN - 1);
        if (emit) m_do = dbit;
        if (restart) m_cnt = 0;
        else if (emit) m_cnt = (m_cnt + 1) % TB_LEN;
        m_state    = restart ? rs : ((m_state >> 1) | (int'(dbit) << (K - 2)));
        m_prev_sel = selection;
    endtask

    task automatic drive(input logic en, input logic sel, input logic [NS-1:0] d0, input logic [NS-1:0] d1);
        enable = en; selection = sel; d_in_0 = d0; d_in_1 = d1;
    endtask

    task automatic step_model(input string tag);
        model_step();
        @(posedge clk); #1;
        chk({tag, ".state_o"}, int'(state_o), m_state);
        chk({tag, ".d_o"},     int'(d_o),     int'(m_do));
        chk({tag, ".wr_en"},   int'(wr_en),   int'(m_wr));
        chk({tag, ".d_last"},  int'(d_last),  int'(m_last));
    endtask

    initial begin
        bit cur_sel;
        int pulses;

        // Reset state
        #12;
        chk("rst.state_o", int'(state_o), 0);
        chk("rst.d_o",     int'(d_o),     0);
        chk("rst.wr_en",   int'(wr_en),   0);
        chk("rst.d_last",  int'(d_last),  0);
        @(negedge clk); rst = 1'b1;
        model_reset();

        // Directed table: FF trace, fall restart, all-zero trace, enable drop, bank-0 walk, 0->1 switch
        tbl[0]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 3'd6, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hAA, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h10, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].sel, tbl[i].d0, tbl[i].d1);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.state_o", i), int'(state_o), int'(tbl[i].st));
            chk($sformatf("tbl%0d.d_o", i),     int'(d_o),     int'(tbl[i].dout));
            chk($sformatf("tbl%0d.wr_en", i),   int'(wr_en),   int'(tbl[i].wr));
            chk($sformatf("tbl%0d.d_last", i),  int'(d_last),  int'(tbl[i].last));
        end

        // Async reset mid-trace clears outputs without a clock edge
        drive(1'b1, 1'b1, 8'h00, 8'hFF);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("arst.state_o", int'(state_o), 0);
        chk("arst.d_o",     int'(d_o),     0);
        chk("arst.wr_en",   int'(wr_en),   0);
        chk("arst.d_last",  int'(d_last),  0);
        @(negedge clk); rst = 1'b1;
        model_reset();

        // Full window: d_last only on the 16th emit, never elsewhere
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, NS'($urandom), NS'($urandom));
            step_model("win");
            if (wr_en) pulses++;
            chk("win.wr_en_pulse", int'(wr_en), 1);
            chk("win.d_last_pos", int'(d_last), int'(pulses == 16));
        end

`ifdef TBU_START_STATE_EN
        // Restart from a supplied start state, then all-zero decisions shift it down
        start_state = 3'd5;
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        step_model("ss0");
        chk("ss.restart", int'(state_o), 5);
        start_state = 3'd0;
        drive(1'b1, 1'b1, 8'h00, 8'h00);
        step_model("ss1");
        chk("ss.first", int'(state_o), 2);
        step_model("ss2");
        chk("ss.second", int'(state_o), 1);
        step_model("ss3");
        chk("ss.third", int'(state_o), 0);
`endif

        // Random traffic with long selection runs against the model
        cur_sel = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) cur_sel = ~cur_sel;
`ifdef TBU_START_STATE_EN
            start_state = SW'($urandom);
`endif
            drive(logic'($urandom_range(0, 19) != 0), cur_sel, NS'($urandom), NS'($urandom));
            step_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
